// File: rtl/fb_sched_pkg.sv
// Shared constants, pixel type and slot encoding for the framebuffer scheduler.
package fb_sched_pkg;

    localparam int FB_W   = 200;
    localparam int FB_H   = 150;
    localparam int ADDR_W = 15;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    typedef enum logic {SLOT_READ, SLOT_WRITE} slot_t;

    // Framebuffer cell index of a screen pixel at 4x4 scaling, before truncation.
    function automatic logic [31:0] cell_index(input logic [9:0] v, input logic [10:0] h,
                                               input int fb_w);
        return 32'(v >> 2) * 32'(fb_w) + 32'(h >> 2);
    endfunction

endpackage

// File: rtl/fb_sched_if.sv
// Write-requester and RAM port bundle of the framebuffer scheduler.
interface fb_sched_if
    import fb_sched_pkg::*;
#(
    parameter int N_WR   = 2,
    parameter int ADDR_W = 15
) ();

    // Handshake: a requester raises wr_req with wr_addr/wr_data and holds all three
    // stable until wr_gnt; the beat transfers in the cycle wr_gnt is high (combinational
    // from wr_req), and in the next cycle the requester drops wr_req or shows its next beat.
    logic [N_WR-1:0]        wr_req;
    logic [N_WR*ADDR_W-1:0] wr_addr;
    logic [N_WR*12-1:0]     wr_data;
    logic [N_WR-1:0]        wr_gnt;

    logic                   mem_en;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    pixel_t                 mem_wdata;
    pixel_t                 mem_rdata;

    modport master (
        input  wr_req, wr_addr, wr_data, mem_rdata,
        output wr_gnt, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output wr_req, wr_addr, wr_data, mem_rdata,
        input  wr_gnt, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/fb_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic         ptr_upd
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic             found;

    // Outer loop walks priority distance from the pointer, inner loop finds that requester.
    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        ptr_nxt = ptr;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (en && !found && req[j] && (((int'(ptr) + i) % N) == j)) begin
                    gnt[j]  = 1'b1;
                    found   = 1'b1;
                    ptr_nxt = PTR_W'((j + 1) % N);
                end
            end
        end
    end

    assign ptr_upd = found;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ptr <= '0;
        end else if (ptr_upd) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/fb_scheduler.sv
// Time-division framebuffer scheduler: scan-out READ slots plus round-robin write slots.
// Define FB_SCHED_TEAR_FREE_EN to confine writes to vertical blanking.
module fb_scheduler
    import fb_sched_pkg::*;
#(
    parameter int FB_W      = fb_sched_pkg::FB_W,
    parameter int FB_H      = fb_sched_pkg::FB_H,
    parameter int ADDR_W    = fb_sched_pkg::ADDR_W,
    parameter int N_WR      = 2,
    parameter int V_VISIBLE = 600
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [10:0] monitor_h_coord,
    input  logic [9:0]  monitor_v_coord,
    input  logic        monitor_enable,
    fb_sched_if.master  bus,
    output logic [3:0]  monitor_r,
    output logic [3:0]  monitor_g,
    output logic [3:0]  monitor_b,
    output logic        wr_err
);

`ifdef FB_SCHED_TEAR_FREE_EN
    localparam bit TEAR_FREE = 1'b1;
`else
    localparam bit TEAR_FREE = 1'b0;
`endif

    slot_t             slot;
    logic              in_vblank;
    logic              wr_slot;
    logic              gnt_any;
    logic              oor;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] sel_addr;
    pixel_t            sel_data;
    logic              rd_d1;
    logic              en_d1;
    logic              en_d2;
    pixel_t            pix_hold;

    assign slot      = (monitor_enable && (monitor_h_coord[1:0] == 2'd0)) ? SLOT_READ : SLOT_WRITE;
    assign in_vblank = 32'(monitor_v_coord) >= 32'(V_VISIBLE);
    // Reset also gates grants so nothing is accepted while state is being cleared.
    assign wr_slot   = arst_n && (slot == SLOT_WRITE) && (!TEAR_FREE || in_vblank);
    assign rd_addr   = ADDR_W'(cell_index(monitor_v_coord, monitor_h_coord, FB_W));

    rr_arbiter #(.N(N_WR)) u_arb (
        .clk     (clk),
        .arst_n  (arst_n),
        .req     (bus.wr_req),
        .en      (wr_slot),
        .gnt     (bus.wr_gnt),
        .ptr_upd (gnt_any)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_WR; i++) begin
            if (bus.wr_gnt[i]) begin
                sel_addr = bus.wr_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.wr_data[i*12 +: 12];
            end
        end
    end

    assign oor = 32'(sel_addr) >= 32'(FB_W * FB_H);

    // An out-of-range beat is still granted (so the requester moves on) but never reaches RAM.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (arst_n && (slot == SLOT_READ)) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = rd_addr;
        end else if (gnt_any) begin
            bus.mem_en    = !oor;
            bus.mem_we    = !oor;
            bus.mem_addr  = sel_addr;
            bus.mem_wdata = sel_data;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_d1    <= 1'b0;
            en_d1    <= 1'b0;
            en_d2    <= 1'b0;
            pix_hold <= '0;
            wr_err   <= 1'b0;
        end else begin
            rd_d1 <= (slot == SLOT_READ);
            en_d1 <= monitor_enable;
            en_d2 <= en_d1;
            if (rd_d1) begin
                pix_hold <= bus.mem_rdata;
            end
            if (gnt_any && oor) begin
                wr_err <= 1'b1;
            end
        end
    end

    assign monitor_r = en_d2 ? pix_hold.r : 4'h0;
    assign monitor_g = en_d2 ? pix_hold.g : 4'h0;
    assign monitor_b = en_d2 ? pix_hold.b : 4'h0;

endmodule

// File: tb/tb_fb_scheduler.sv
// Self-checking bench for fb_scheduler: RAM model, colour scoreboard, arbitration model.
module tb_fb_scheduler;

    localparam int N  = 2;
    localparam int AW = 15;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [10:0] h_coord = '0;
    logic [9:0]  v_coord = '0;
    logic        enable = 1'b0;
    logic [3:0]  r, g, b;
    logic        wr_err;

    fb_sched_if #(.N_WR(N), .ADDR_W(AW)) bus ();

    fb_scheduler #(.N_WR(N)) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .monitor_h_coord (h_coord),
        .monitor_v_coord (v_coord),
        .monitor_enable  (enable),
        .bus             (bus),
        .monitor_r       (r),
        .monitor_g       (g),
        .monitor_b       (b),
        .wr_err          (wr_err)
    );

    always #5 clk = ~clk;

    // ---------------- clock/reset helpers and RAM model ----------------
    logic [11:0] ram [0:32767];
    logic        ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 32768; i++) ram[i] <= 12'($urandom_range(0, 4095));
            ram[2019]  <= 12'h123;
            ram[2020]  <= 12'hA5C;
            ram[2021]  <= 12'h3C7;
            ram[2022]  <= 12'h0F0;
            ram_ready  <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [11:0] exp_q[$];
    logic [11:0] exp_colour;
    logic [11:0] model_hold = '0;
    bit          sb_on = 1'b0;
    bit          release_now = 1'b0;
    int          rr_ptr = 0;
    bit          err_model = 1'b0;
    bit          pend[N];
    int          beat[N];
    logic [N-1:0] arm_mask = '0;
    bit          oor_next = 1'b0;
    bit          keep_mode = 1'b0;
    bit          rand_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int cell_of(input int h, input int v);
        return ((v / 4) * 200 + (h / 4)) % 32768;
    endfunction

    // Colour produced in cycle t+2 is compared against the value pushed in cycle t.
    always @(negedge clk) begin
        if (exp_q.size() >= 3) begin
            exp_colour = exp_q.pop_front();
            check("colour", 32'({r, g, b}), 32'(exp_colour));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int h, input int v, input bit en);
        @(posedge clk);
        #1;
        if (release_now) begin
            arst_n      = 1'b1;
            release_now = 1'b0;
            sb_on       = 1'b1;
        end
        h_coord = 11'(h);
        v_coord = 10'(v);
        enable  = en;
        if (sb_on) begin
            if (en && (h % 4 == 0)) model_hold = ram[15'(cell_of(h, v))];
            exp_q.push_back(en ? model_hold : 12'h000);
        end
    endtask

    task automatic set_req(input int i, input bit on, input logic [AW-1:0] addr,
                           input logic [11:0] data);
        bus.wr_req[i]              = on;
        bus.wr_addr[i*AW +: AW]    = addr;
        bus.wr_data[i*12 +: 12]    = data;
    endtask

    task automatic next_beat(input int i);
        beat[i]++;
        set_req(i, 1'b1, AW'(5000 + 100 * i + beat[i]), 12'($urandom_range(0, 4095)));
    endtask

    task automatic drop_all();
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b0, '0, '0);
            pend[i] = 1'b0;
        end
    endtask

    task automatic update_reqs();
        for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
                pend[i] = 1'b0;
                if (keep_mode) next_beat(i);
                else           set_req(i, 1'b0, '0, '0);
            end else if (arm_mask[i]) begin
                if (oor_next && i == 0) set_req(0, 1'b1, AW'(30000), 12'hFFF);
                else                    next_beat(i);
            end
            if (rand_mode && !bus.wr_req[i] && ($urandom_range(0, 1) == 1)) next_beat(i);
        end
        arm_mask = '0;
        oor_next = 1'b0;
    endtask

    task automatic check_cycle(input int h, input int v, input bit en, output int win);
        bit              rd;
        bit              wok;
        logic [31:0]     rq;
        logic [AW-1:0]   a;
        logic [11:0]     d;
        rd  = en && (h % 4 == 0);
        wok = !rd;
`ifdef FB_SCHED_TEAR_FREE_EN
        if (v < 600) wok = 1'b0;
`endif
        win = -1;
        rq  = 32'(bus.wr_req);
        if (wok) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (rr_ptr + k) % N;
                if (win < 0 && ((rq >> idx) & 32'd1) != 0) win = idx;
            end
        end
        check("wr_err", 32'(wr_err), 32'(err_model));
        check("wr_gnt", 32'(bus.wr_gnt), (win < 0) ? 32'd0 : (32'd1 << win));
        if (rd) begin
            check("rd_en_we", 32'({bus.mem_en, bus.mem_we}), 32'b10);
            check("rd_addr", 32'(bus.mem_addr), 32'(cell_of(h, v)));
        end else if (win >= 0) begin
            a      = bus.wr_addr[win*AW +: AW];
            d      = bus.wr_data[win*12 +: 12];
            rr_ptr = (win + 1) % N;
            if (int'(a) >= 30000) begin
                check("oor_mem_en", 32'(bus.mem_en), 32'd0);
                err_model = 1'b1;
            end else begin
                check("wr_en_we", 32'({bus.mem_en, bus.mem_we}), 32'b11);
                check("wr_addr", 32'(bus.mem_addr), 32'(a));
                check("wr_data", 32'(bus.mem_wdata), 32'(d));
            end
        end else begin
            check("idle_mem_en", 32'(bus.mem_en), 32'd0);
        end
    endtask

    task automatic step(input int h, input int v, input bit en);
        int win;
        tick(h, v, en);
        update_reqs();
        @(negedge clk);
        check_cycle(h, v, en, win);
        if (win >= 0) pend[win] = 1'b1;
    endtask

    task automatic run(input int h0, input int v, input bit en, input int n);
        for (int c = 0; c < n; c++) step(h0 + c, v, en);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        int first_h;
        bus.wr_req = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            beat[i] = 0;
        end

        // Reset state.
        for (int c = 0; c < 3; c++) begin
            tick(0, 620, 1'b0);
            @(negedge clk);
            check("rst_colour", 32'({r, g, b}), 32'd0);
            check("rst_gnt", 32'(bus.wr_gnt), 32'd0);
            check("rst_mem_en", 32'(bus.mem_en), 32'd0);
            check("rst_wr_err", 32'(wr_err), 32'd0);
        end
        release_now = 1'b1;
        run(0, 620, 1'b0, 4);

        // Fill check: cell (10,20) holds A5C, scanned at v=40, h=80..83.
        cnt = 0;
        first_h = -1;
        for (int h = 76; h < 94; h++) begin
            step(h, 40, h < 92);
            if ({r, g, b} == 12'hA5C) begin
                cnt++;
                if (first_h < 0) first_h = h;
            end
        end
        check("a5c_cycles", 32'(cnt), 32'd4);
        check("a5c_first_h", 32'(first_h), 32'd82);

`ifndef FB_SCHED_TEAR_FREE_EN
        // READ-slot blocking: requester 0 continuous from h=4 on a visible line.
        keep_mode = 1'b1;
        arm_mask  = 2'b01;
        run(4, 40, 1'b1, 8);
        drop_all();
        run(12, 40, 1'b1, 4);
`endif

        // Reset one cycle after a READ slot, with a request pending.
        run(76, 40, 1'b1, 5);
        tick(81, 40, 1'b1);
        arst_n = 1'b0;
        sb_on  = 1'b0;
        exp_q.delete();
        model_hold = '0;
        rr_ptr     = 0;
        err_model  = 1'b0;
        drop_all();
        set_req(0, 1'b1, AW'(6000), 12'h777);
        for (int h = 81; h < 84; h++) begin
            if (h > 81) tick(h, 40, 1'b1);
            @(negedge clk);
            check("midrst_colour", 32'({r, g, b}), 32'd0);
            check("midrst_gnt", 32'(bus.wr_gnt), 32'd0);
        end
        drop_all();
        release_now = 1'b1;
        for (int h = 84; h < 86; h++) begin
            step(h, 40, 1'b1);
            check("post_rst_colour", 32'({r, g, b}), 32'd0);
        end
        run(86, 40, 1'b1, 8);

        // Round-robin fairness in blanking: both requesters continuous.
        keep_mode = 1'b1;
        arm_mask  = 2'b11;
        run(0, 620, 1'b0, 8);
        drop_all();
        // Random request traffic against the arbitration model.
        keep_mode = 1'b0;
        rand_mode = 1'b1;
        run(8, 620, 1'b0, 24);
        rand_mode = 1'b0;
        drop_all();
        run(32, 620, 1'b0, 2);

        // Out-of-range write: granted, dropped, sticky error.
        keep_mode = 1'b0;
        rr_ptr    = rr_ptr;
        arm_mask  = 2'b01;
        oor_next  = 1'b1;
        run(0, 620, 1'b0, 5);
        check("wr_err_held", 32'(wr_err), 32'd1);
        arm_mask = 2'b11;
        run(5, 620, 1'b0, 3);

`ifdef FB_SCHED_TEAR_FREE_EN
        // Requests wait through the visible area, then win the first blanking cycle.
        drop_all();
        arm_mask = 2'b01;
        run(0, 100, 1'b1, 16);
        run(0, 600, 1'b0, 1);
`endif

        drop_all();
        run(0, 620, 1'b0, 3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
